// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (watchdog + sticky mem_err).
package mem_arb_pkg;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  // Fetch loses at most this many arbitrations in a row before it is forced in.
  localparam logic [2:0] STARVE_LIMIT = 3'd4;

  // WAIT-state cycles without mem_ready before the watchdog abandons a transaction.
  localparam int TIMEOUT_CYCLES = 64;

  // Fetches are always 32-bit word accesses.
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } arb_state_t;

  // Saturating increment of the fetch starvation counter.
  function automatic logic [2:0] starve_inc(input logic [2:0] cnt);
    return (cnt >= STARVE_LIMIT) ? STARVE_LIMIT : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts consecutive WAIT-state cycles and flags expiry when the memory
// has not answered within TIMEOUT_CYCLES. Only used with MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [6:0] count_reg;
  logic [6:0] count_next;

  // Expire in the last allowed WAIT cycle when no completion arrives.
  always_comb begin
    expired    = active && !ready && (count_reg == 7'(TIMEOUT_CYCLES - 1));
    count_next = count_reg + 7'd1;
    if (!active || ready || expired) begin
      count_next = '0;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port with
// exactly one outstanding transaction. Data wins unless fetch has been
// starved STARVE_LIMIT times. Optional macro: MEM_ARB_TIMEOUT_EN adds a
// watchdog that abandons a hung transaction and sets a sticky mem_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [INSTR_W-1:0]  if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [2:0]          dm_funct3,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [2:0]          mem_size,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                mem_err
`endif
);

  arb_state_t         state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [DATA_W-1:0]  wdata_reg, wdata_next;
  logic               we_reg, we_next;
  logic [2:0]         size_reg, size_next;
  logic [2:0]         starve_reg, starve_next;
  logic [INSTR_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]  dm_rdata_reg, dm_rdata_next;
  logic               if_valid_reg, if_valid_next;
  logic               dm_valid_reg, dm_valid_next;
  logic               if_qual, dm_qual;
  logic               wd_expired;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_reg;

  mem_arb_watchdog u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (state_reg != IDLE),
    .ready   (mem_ready),
    .expired (wd_expired)
  );

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (wd_expired) begin
      err_reg <= 1'b1;
    end
  end

  assign mem_err = err_reg;
`else
  assign wd_expired = 1'b0;
`endif

  // A request whose completion pulse is showing this cycle is already
  // served; it must not win a second grant.
  assign if_qual = if_req && !if_valid_reg;
  assign dm_qual = dm_req && !dm_valid_reg;

  // Next-state, grant and completion logic.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    we_next       = we_reg;
    size_next     = size_reg;
    starve_next   = starve_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;
    if_valid_next = 1'b0;
    dm_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (if_qual && (!dm_qual || starve_reg == STARVE_LIMIT)) begin
          addr_next   = if_addr;
          wdata_next  = '0;
          we_next     = 1'b0;
          size_next   = FETCH_SIZE;
          starve_next = '0;
          state_next  = IF_WAIT;
        end else if (dm_qual) begin
          addr_next  = dm_addr;
          wdata_next = dm_wdata;
          we_next    = dm_we;
          size_next  = dm_funct3;
          state_next = DM_WAIT;
          if (if_qual) begin
            starve_next = starve_inc(starve_reg);
          end
        end
      end
      IF_WAIT: begin
        if (mem_ready) begin
          if_rdata_next = mem_rdata[INSTR_W-1:0];
          if_valid_next = 1'b1;
          state_next    = IDLE;
        end else if (wd_expired) begin
          if_rdata_next = '0;
          if_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      DM_WAIT: begin
        if (mem_ready) begin
          // Stores complete without disturbing the last load value.
          if (!we_reg) begin
            dm_rdata_next = mem_rdata;
          end
          dm_valid_next = 1'b1;
          state_next    = IDLE;
        end else if (wd_expired) begin
          dm_rdata_next = '0;
          dm_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and latched transaction registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      size_reg     <= '0;
      starve_reg   <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      if_valid_reg <= 1'b0;
      dm_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      we_reg       <= we_next;
      size_reg     <= size_next;
      starve_reg   <= starve_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
      if_valid_reg <= if_valid_next;
      dm_valid_reg <= dm_valid_next;
    end
  end

  assign mem_req   = (state_reg == IF_WAIT) || (state_reg == DM_WAIT);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_size  = size_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_valid  = if_valid_reg;
  assign dm_valid  = dm_valid_reg;
  assign stall_if  = if_req && !if_valid_reg;
  assign stall_mem = dm_req && !dm_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Exercises the timeout path as well when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [2:0]  dm_funct3;
  logic [63:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        mem_err;
`endif

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_funct3 (dm_funct3),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_size  (mem_size),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .mem_err   (mem_err)
`endif
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_funct3 = '0; mem_ready = 0; mem_rdata = '0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
    checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got if=%0h dm=%0h expected 0 0", if_valid, dm_valid); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got if=%h dm=%h expected 0", if_rdata, dm_rdata); end
    checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_size !== 3'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_port: got addr=%h wdata=%h size=%0h we=%0h expected all 0", mem_addr, mem_wdata, mem_size, mem_we); end
    checks++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h %0h expected 0 0", stall_if, stall_mem); end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 64'h10;
    #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_req: got %0h expected 1", stall_if); end
    tick(); // cycle 1
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h10) begin errors++; $display("FAIL fetch_cycle1: got req=%0h addr=%h expected 1 10", mem_req, mem_addr); end
    checks++; if (mem_size !== 3'b010 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_size_we: got size=%0h we=%0h expected 2 0", mem_size, mem_we); end
    mem_ready = 1; mem_rdata = 64'h00000000_00500093;
    tick(); // cycle 2
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_valid: got valid=%0h rdata=%h expected 1 00500093", if_valid, if_rdata); end
    checks++; if (mem_req !== 1'b0 || stall_if !== 1'b0) begin errors++; $display("FAIL fetch_done_req_stall: got req=%0h stall=%0h expected 0 0", mem_req, stall_if); end
    $display("fetch addr=%h rdata=%h", 64'h10, if_rdata);
    if_req = 0; mem_ready = 0;
    tick();
    checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_hold: got valid=%0h rdata=%h expected 0 00500093", if_valid, if_rdata); end
    // mem_ready with nothing outstanding must be ignored.
    mem_ready = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_ignored: got req=%0h ifv=%0h dmv=%0h expected 0 0 0", mem_req, if_valid, dm_valid); end
    mem_ready = 0;
    tick();
  endtask

  task automatic test_priority();
    if_req = 1; if_addr = 64'h20;
    dm_req = 1; dm_we = 0; dm_addr = 64'h100; dm_funct3 = 3'b011;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h100 || mem_size !== 3'b011) begin errors++; $display("FAIL prio_dm_first: got req=%0h addr=%h size=%0h expected 1 100 3", mem_req, mem_addr, mem_size); end
    mem_ready = 1; mem_rdata = 64'h11223344_55667788;
    tick(); // dm_valid cycle, dm_req still held
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h11223344_55667788) begin errors++; $display("FAIL prio_dm_valid: got valid=%0h rdata=%h expected 1 1122334455667788", dm_valid, dm_rdata); end
    $display("load addr=%h rdata=%h", 64'h100, dm_rdata);
    mem_ready = 0;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h20 || mem_size !== 3'b010) begin errors++; $display("FAIL prio_no_dup_grant: got req=%0h addr=%h size=%0h expected 1 20 2", mem_req, mem_addr, mem_size); end
    dm_req = 0;
    mem_ready = 1; mem_rdata = 64'hAAAABBBB_00000013;
    tick();
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00000013 || dm_rdata !== 64'h11223344_55667788) begin errors++; $display("FAIL prio_fetch_done: got valid=%0h if=%h dm=%h expected 1 00000013 1122334455667788", if_valid, if_rdata, dm_rdata); end
    $display("fetch addr=%h rdata=%h", 64'h20, if_rdata);
    if_req = 0; mem_ready = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic [63:0] exp_addr;
    for (int k = 0; k < 5; k++) begin
      if_req = 1; if_addr = 64'h40;
      dm_req = 1; dm_we = 0; dm_funct3 = 3'b011; dm_addr = 64'h300 + 64'(k * 8);
      tick();
      exp_addr = (k < 4) ? dm_addr : 64'h40;
      checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin errors++; $display("FAIL starve_arb%0d: got req=%0h addr=%h expected 1 %h", k, mem_req, mem_addr, exp_addr); end
      mem_ready = 1; mem_rdata = 64'h50 + 64'(k);
      tick();
      if (k < 4) begin
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h50 + 64'(k)) begin errors++; $display("FAIL starve_dm%0d: got valid=%0h rdata=%h expected 1 %h", k, dm_valid, dm_rdata, 64'h50 + 64'(k)); end
        $display("load addr=%h rdata=%h", dm_addr, dm_rdata);
        if_req = 0; mem_ready = 0;
        tick();
      end else begin
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h54) begin errors++; $display("FAIL starve_if_valid: got valid=%0h rdata=%h expected 1 00000054", if_valid, if_rdata); end
        $display("fetch addr=%h rdata=%h", 64'h40, if_rdata);
        if_req = 0; mem_ready = 0;
        tick(); // held dm_req granted in the fetch's valid cycle
        checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h320) begin errors++; $display("FAIL starve_dm_after: got req=%0h addr=%h expected 1 320", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 64'h55;
        tick();
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h55) begin errors++; $display("FAIL starve_dm_last: got valid=%0h rdata=%h expected 1 55", dm_valid, dm_rdata); end
        $display("load addr=%h rdata=%h", 64'h320, dm_rdata);
        dm_req = 0; mem_ready = 0;
        tick();
      end
    end
  endtask

  task automatic test_store();
    int valid_count;
    dm_req = 1; dm_we = 1; dm_addr = 64'h200; dm_wdata = 64'hDEADBEEF; dm_funct3 = 3'b011;
    tick();
    checks++; if (mem_addr !== 64'h200 || mem_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL store_port: got addr=%h wdata=%h expected 200 deadbeef", mem_addr, mem_wdata); end
    valid_count = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || stall_mem !== 1'b1 || dm_valid !== 1'b0) begin errors++; $display("FAIL store_wait%0d: got req=%0h we=%0h stall=%0h valid=%0h expected 1 1 1 0", i, mem_req, mem_we, stall_mem, dm_valid); end
      mem_ready = (i == 2); mem_rdata = 64'hFFFF_0000_FFFF_0000;
      tick();
      if (dm_valid) valid_count++;
    end
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h55 || mem_req !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL store_done: got valid=%0h rdata=%h req=%0h stall=%0h expected 1 55 0 0", dm_valid, dm_rdata, mem_req, stall_mem); end
    $display("store addr=%h wdata=%h", 64'h200, 64'hDEADBEEF);
    dm_req = 0; dm_we = 0; mem_ready = 0;
    tick();
    if (dm_valid) valid_count++;
    checks++; if (valid_count !== 1) begin errors++; $display("FAIL store_valid_once: got %0d pulses expected 1", valid_count); end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    dm_req = 1; dm_we = 0; dm_addr = 64'h400; dm_funct3 = 3'b011; mem_ready = 0;
    tick();
    for (int i = 1; i <= 64; i++) begin
      checks++; if (mem_req !== 1'b1 || dm_valid !== 1'b0) begin errors++; $display("FAIL timeout_wait%0d: got req=%0h valid=%0h expected 1 0", i, mem_req, dm_valid); end
      tick();
    end
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h0 || mem_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_expire: got valid=%0h rdata=%h err=%0h req=%0h expected 1 0 1 0", dm_valid, dm_rdata, mem_err, mem_req); end
    $display("load addr=%h timed out", 64'h400);
    dm_req = 0;
    tick(); tick();
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0h expected 1", mem_err); end
  endtask
`endif

  task automatic test_reset_midflight();
    dm_req = 1; dm_we = 0; dm_addr = 64'h180; dm_funct3 = 3'b011;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h180) begin errors++; $display("FAIL rstmid_grant: got req=%0h addr=%h expected 1 180", mem_req, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 64'h0 || dm_rdata !== 64'h0) begin errors++; $display("FAIL rstmid_async: got req=%0h addr=%h rdata=%h expected 0 0 0", mem_req, mem_addr, dm_rdata); end
`ifdef MEM_ARB_TIMEOUT_EN
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rstmid_err: got %0h expected 0", mem_err); end
`endif
    mem_ready = 1; mem_rdata = 64'h99;
    tick();
    checks++; if (dm_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid: got valid=%0h req=%0h expected 0 0", dm_valid, mem_req); end
    mem_ready = 0;
    #3 rst_n = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h180) begin errors++; $display("FAIL rstmid_regrant: got req=%0h addr=%h expected 1 180", mem_req, mem_addr); end
    mem_ready = 1; mem_rdata = 64'h77;
    tick();
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 64'h77) begin errors++; $display("FAIL rstmid_done: got valid=%0h rdata=%h expected 1 77", dm_valid, dm_rdata); end
    $display("load addr=%h rdata=%h (after reset)", 64'h180, dm_rdata);
    dm_req = 0; mem_ready = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_store();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "bench time limit reached");
  end

endmodule
